// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and the byte-addressed data memory.
// One request in flight: checks it, runs one memory cycle, formats the result.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_we_o,
    output logic [2:0]  mem_op_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_din_o,
    input  logic [31:0] mem_dout_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [4:0]  rsp_rd_o,
    output logic        rsp_fault_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

    state_e      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rsp_rd_q;
    logic        rsp_fault_q;

    logic        accept;
    logic        req_fault;
    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic [31:0] rsp_data_d;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        in_access;

    always_comb begin
        nbytes = 3'd4;
        unique case (req_size_i)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign end_addr  = {1'b0, req_addr_i} + {30'b0, nbytes};
    assign req_fault = (req_size_i == 2'b11)
                     | ((req_size_i == 2'b01) & req_addr_i[0])
                     | ((req_size_i == 2'b10) & (|req_addr_i[1:0]))
                     | (end_addr > LIMIT);

    assign req_ready_o = ~reset_i & ((state_q == IDLE)
                       | ((state_q == RESP) & rsp_ready_i));
    assign accept      = req_valid_i & req_ready_o;

    assign in_access  = (state_q == ACCESS);
    assign mem_we_o   = in_access & we_q & ~reset_i;
    assign mem_op_o   = in_access ? {size_q == 2'b10, size_q == 2'b01,
                                     size_q == 2'b00} : 3'b000;
    assign mem_addr_o = in_access ? addr_q : 32'd0;
    assign mem_din_o  = in_access ? wdata_q : 32'd0;

    // memory returns the lowest-addressed byte in the top lane
    assign ld_b = mem_dout_i[31:24];
    assign ld_h = {mem_dout_i[23:16], mem_dout_i[31:24]};

    always_comb begin
        rsp_data_d = 32'd0;
        if (!we_q) begin
            unique case (size_q)
                2'b00:   rsp_data_d = {{24{signed_q & ld_b[7]}}, ld_b};
                2'b01:   rsp_data_d = {{16{signed_q & ld_h[15]}}, ld_h};
                default: rsp_data_d = {mem_dout_i[7:0], mem_dout_i[15:8],
                                       mem_dout_i[23:16], mem_dout_i[31:24]};
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            rsp_data_q  <= 32'd0;
            rsp_rd_q    <= 5'd0;
            rsp_fault_q <= 1'b0;
        end else if (accept) begin
            we_q     <= req_we_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            rd_q     <= req_rd_i;
            if (req_fault) begin
                state_q     <= RESP;
                rsp_data_q  <= 32'd0;
                rsp_rd_q    <= req_rd_i;
                rsp_fault_q <= 1'b1;
            end else begin
                state_q <= ACCESS;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ACCESS: begin
                    state_q     <= RESP;
                    rsp_data_q  <= rsp_data_d;
                    rsp_rd_q    <= rd_q;
                    rsp_fault_q <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_rd_o    = rsp_rd_q;
    assign rsp_fault_o = rsp_fault_q;
    assign busy_o      = (state_q != IDLE);

endmodule
